// File: rtl/memio_pkg.sv
// memio_pkg: shared types and address decode for the memory-IO controller.
// Region/state enums, region base/mask constants, decode_region() helper.
package memio_pkg;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_ROM,
        REG_RAM,
        REG_GPIO
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_e;

    localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE    = 32'h0000_2000;
    localparam logic [31:0] REGION_MASK = 32'hFFFF_E000;

    // GPIO window holds two registers per bank (out latch, sync input);
    // offsets past the last bank fall through to unmapped.
    function automatic region_e decode_region(
        input logic [31:0] addr,
        input logic [31:0] gpio_base,
        input int unsigned banks
    );
        if ((addr & REGION_MASK) == ROM_BASE)
            return REG_ROM;
        if ((addr & REGION_MASK) == RAM_BASE)
            return REG_RAM;
        if (addr >= gpio_base && (addr - gpio_base) < 32'(2 * banks))
            return REG_GPIO;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/memio_gpio_bank.sv
// memio_gpio_bank: one IO bank - output latch, 2-flop input sync, read mux.
// Ports: we_i/wdata_i load the latch; pin_i raw pins; rd_in_i picks input reg.
module memio_gpio_bank
    import memio_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] pin_i,
    input  logic              rd_in_i,
    output logic [DATA_W-1:0] out_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] sync1_q;
    logic [DATA_W-1:0] sync2_q;

    assign out_d = we_i ? wdata_i : out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= RESET_VAL;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            out_q   <= out_d;
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    assign out_o   = out_q;
    assign rdata_o = rd_in_i ? sync2_q : out_q;

endmodule

// File: rtl/memio_ctrl.sv
// memio_ctrl: clocked ROM/RAM/GPIO decoder with per-region wait states.
// Ports: cpu_* core handshake, mem_*/cs_n external bus, gpio_in/gpio_out banks.
// Build option MEMIO_BUS_ERR_EN adds bus_err, pulsed with cpu_ready on errors.
module memio_ctrl
    import memio_pkg::*;
#(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       GPIO_BANKS = 2,
    parameter int unsigned       ROM_WAIT   = 1,
    parameter int unsigned       RAM_WAIT   = 1,
    parameter logic [ADDR_W-1:0] GPIO_BASE  = 16'hF000,
    parameter logic [DATA_W-1:0] GPIO_RESET = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_rd,
    input  logic                         cpu_wr,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_ready,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         mem_oe,
    output logic                         rom_cs_n,
    output logic                         ram_cs_n,
    output logic                         mem_we_n,
    input  logic [GPIO_BANKS*DATA_W-1:0] gpio_in,
    output logic [GPIO_BANKS*DATA_W-1:0] gpio_out
`ifdef MEMIO_BUS_ERR_EN
    ,
    output logic                         bus_err
`endif
);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              ready_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] mwdata_q;
    logic              oe_q;
    logic              rom_cs_q;
    logic              ram_cs_q;
    logic              we_n_q;

    logic [31:0]       addr32;
    logic [31:0]       base32;
    logic [3:0]        goff;
    logic [2:0]        gidx;
    region_e           region;
    logic              accept;
    logic [DATA_W-1:0] gpio_rd;
    logic [DATA_W-1:0] bank_rdata [GPIO_BANKS];

    assign addr32 = 32'(cpu_addr);
    assign base32 = 32'(GPIO_BASE);
    assign goff   = 4'(addr32 - base32);
    assign gidx   = goff[3:1];
    assign region = decode_region(addr32, base32, GPIO_BANKS);
    assign accept = (state_q == ST_IDLE) && (cpu_rd ^ cpu_wr);

    // Even offsets are the out latch, odd offsets the read-only input.
    for (genvar k = 0; k < GPIO_BANKS; k++) begin : g_bank
        logic we;
        assign we = accept && cpu_wr && (region == REG_GPIO)
                    && !goff[0] && (gidx == 3'(k));
        memio_gpio_bank #(
            .DATA_W    (DATA_W),
            .RESET_VAL (GPIO_RESET)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .we_i    (we),
            .wdata_i (cpu_wdata),
            .pin_i   (gpio_in[k*DATA_W +: DATA_W]),
            .rd_in_i (goff[0]),
            .out_o   (gpio_out[k*DATA_W +: DATA_W]),
            .rdata_o (bank_rdata[k])
        );
    end

    always_comb begin
        gpio_rd = '0;
        for (int k = 0; k < GPIO_BANKS; k++)
            if (gidx == 3'(k))
                gpio_rd = bank_rdata[k];
    end

`ifdef MEMIO_BUS_ERR_EN
    logic err_q;
    logic bus_err_q;
    assign bus_err = bus_err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            oe_q     <= 1'b0;
            rom_cs_q <= 1'b1;
            ram_cs_q <= 1'b1;
            we_n_q   <= 1'b1;
`ifdef MEMIO_BUS_ERR_EN
            err_q     <= 1'b0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    if (accept) begin
                        maddr_q  <= cpu_addr;
                        mwdata_q <= cpu_wdata;
                        unique case (region)
                            REG_ROM: begin
                                cnt_q    <= 4'(ROM_WAIT);
                                rom_cs_q <= 1'b0;
                                state_q  <= ST_ACCESS;
                            end
                            REG_RAM: begin
                                cnt_q    <= 4'(RAM_WAIT);
                                ram_cs_q <= 1'b0;
                                we_n_q   <= ~cpu_wr;
                                oe_q     <= cpu_wr;
                                state_q  <= ST_ACCESS;
                            end
                            default: begin
                                rdata_q <= (region == REG_GPIO && cpu_rd)
                                           ? gpio_rd : '0;
                                ready_q <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        endcase
`ifdef MEMIO_BUS_ERR_EN
                        err_q     <= (region == REG_NONE)
                                     || (region == REG_ROM && cpu_wr);
                        bus_err_q <= (region == REG_NONE);
`endif
                    end
`ifdef MEMIO_BUS_ERR_EN
                    // Collision completes as an error without touching the bus.
                    else if (cpu_rd && cpu_wr) begin
                        rdata_q   <= '0;
                        ready_q   <= 1'b1;
                        bus_err_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
`endif
                end
                ST_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q  <= mem_rdata;
                        rom_cs_q <= 1'b1;
                        ram_cs_q <= 1'b1;
                        we_n_q   <= 1'b1;
                        oe_q     <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= ST_DONE;
`ifdef MEMIO_BUS_ERR_EN
                        bus_err_q <= err_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
`ifdef MEMIO_BUS_ERR_EN
                    bus_err_q <= 1'b0;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_ready = ready_q;
    assign cpu_rdata = rdata_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
    assign mem_oe    = oe_q;
    assign rom_cs_n  = rom_cs_q;
    assign ram_cs_n  = ram_cs_q;
    assign mem_we_n  = we_n_q;

endmodule

// File: tb/tb_memio_ctrl.sv
// tb_memio_ctrl: directed scoreboard bench for memio_ctrl.
// ROM_WAIT=0, RAM_WAIT=1, two GPIO banks at F000.
module tb_memio_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_oe;
    logic        rom_cs_n;
    logic        ram_cs_n;
    logic        mem_we_n;
    logic [15:0] gpio_in = '0;
    logic [15:0] gpio_out;
`ifdef MEMIO_BUS_ERR_EN
    logic        bus_err;
`endif

    memio_ctrl #(
        .DATA_W     (8),
        .ADDR_W     (16),
        .GPIO_BANKS (2),
        .ROM_WAIT   (0),
        .RAM_WAIT   (1),
        .GPIO_BASE  (16'hF000),
        .GPIO_RESET (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_oe    (mem_oe),
        .rom_cs_n  (rom_cs_n),
        .ram_cs_n  (ram_cs_n),
        .mem_we_n  (mem_we_n),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out)
`ifdef MEMIO_BUS_ERR_EN
        ,
        .bus_err   (bus_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rdata;
        int         cyc;
        logic       err;
        bit         chk_data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ram_lo = 0, rom_lo = 0, we_lo = 0, oe_hi = 0;
    int   ready_cnt = 0;
    int   b_ram, b_rom, b_we, b_oe, rc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Strobe levels are tallied per completed cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!ram_cs_n) ram_lo <= ram_lo + 1;
        if (!rom_cs_n) rom_lo <= rom_lo + 1;
        if (!mem_we_n) we_lo  <= we_lo + 1;
        if (mem_oe)    oe_hi  <= oe_hi + 1;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (cpu_ready) ready_cnt++;
        if (!reset && cpu_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ready_cycle", cyc, e.cyc);
                if (e.chk_data) chk("rdata", {24'd0, cpu_rdata}, {24'd0, e.rdata});
`ifdef MEMIO_BUS_ERR_EN
                chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
`endif
            end
        end
    end

    task automatic snap();
        b_ram = ram_lo;
        b_rom = rom_lo;
        b_we  = we_lo;
        b_oe  = oe_hi;
    endtask

    // Called on a negedge; returns on the negedge showing cpu_ready.
    task automatic xfer(input logic rd, input logic wr,
                        input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] er, input bit cd,
                        input int lat, input logic ee);
        exp_t e;
        e.rdata    = er;
        e.cyc      = cyc + lat;
        e.err      = ee;
        e.chk_data = cd;
        sb.push_back(e);
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = a;
        cpu_wdata = wd;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cpu_ready) break;
        end
        if (!cpu_ready) chk("ready_timeout", 32'd0, 32'd1);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_oe", {31'd0, mem_oe}, 32'd0);
        chk("rst_strobes", {29'd0, rom_cs_n, ram_cs_n, mem_we_n}, 32'h7);
        chk("rst_gpio_out", {16'd0, gpio_out}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        snap();
        xfer(1'b0, 1'b1, 16'h2005, 8'hA5, 8'h00, 1'b0, 3, 1'b0);
        chk("ramwr_cs_cycles", ram_lo - b_ram, 32'd2);
        chk("ramwr_we_cycles", we_lo - b_we, 32'd2);
        chk("ramwr_oe_cycles", oe_hi - b_oe, 32'd2);
        chk("ramwr_no_rom", rom_lo - b_rom, 32'd0);
        chk("ramwr_mem_addr", {16'd0, mem_addr}, 32'h2005);
        chk("ramwr_mem_wdata", {24'd0, mem_wdata}, 32'hA5);
        @(negedge clk);

        mem_rdata = 8'h3C;
        snap();
        xfer(1'b1, 1'b0, 16'h0010, 8'h00, 8'h3C, 1'b1, 2, 1'b0);
        chk("romrd_cs_cycles", rom_lo - b_rom, 32'd1);
        chk("romrd_no_ram", ram_lo - b_ram, 32'd0);
        chk("romrd_no_we", we_lo - b_we, 32'd0);
        chk("romrd_no_oe", oe_hi - b_oe, 32'd0);
        @(negedge clk);

        xfer(1'b0, 1'b1, 16'hF002, 8'h5A, 8'h00, 1'b0, 1, 1'b0);
        chk("gpio_wr_latch", {16'd0, gpio_out}, 32'h5A00);
        @(negedge clk);
        xfer(1'b1, 1'b0, 16'hF002, 8'h00, 8'h5A, 1'b1, 1, 1'b0);
        @(negedge clk);
        xfer(1'b0, 1'b1, 16'hF003, 8'hFF, 8'h00, 1'b0, 1, 1'b0);
        chk("gpio_in_reg_wr_ignored", {16'd0, gpio_out}, 32'h5A00);
        @(negedge clk);

        gpio_in = 16'h0081;
        xfer(1'b1, 1'b0, 16'hF001, 8'h00, 8'h00, 1'b1, 1, 1'b0);
        @(negedge clk);
        xfer(1'b1, 1'b0, 16'hF001, 8'h00, 8'h81, 1'b1, 1, 1'b0);
        @(negedge clk);

        mem_rdata = 8'hEE;
        snap();
        xfer(1'b1, 1'b0, 16'h8000, 8'h00, 8'h00, 1'b1, 1, 1'b1);
        chk("unmapped_no_cs", (ram_lo - b_ram) + (rom_lo - b_rom), 32'd0);
        @(negedge clk);
        xfer(1'b1, 1'b0, 16'hF004, 8'h00, 8'h00, 1'b1, 1, 1'b1);
        @(negedge clk);

        snap();
        xfer(1'b0, 1'b1, 16'h0020, 8'h11, 8'h00, 1'b0, 2, 1'b1);
        chk("romwr_cs_cycles", rom_lo - b_rom, 32'd1);
        chk("romwr_no_we", we_lo - b_we, 32'd0);
        @(negedge clk);

        snap();
`ifdef MEMIO_BUS_ERR_EN
        xfer(1'b1, 1'b1, 16'h2000, 8'h00, 8'h00, 1'b1, 1, 1'b1);
`else
        rc = ready_cnt;
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b1;
        cpu_addr = 16'h2000;
        repeat (4) @(negedge clk);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        @(posedge clk);
        chk("collision_no_ready", ready_cnt - rc, 32'd0);
        @(negedge clk);
`endif
        chk("collision_no_strobe", (ram_lo - b_ram) + (rom_lo - b_rom), 32'd0);
        @(negedge clk);

        rc = ready_cnt;
        cpu_rd   = 1'b1;
        cpu_addr = 16'h2100;
        @(negedge clk);
        chk("pre_reset_ram_cs", {31'd0, ram_cs_n}, 32'd0);
        reset  = 1'b1;
        cpu_rd = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {29'd0, rom_cs_n, ram_cs_n, mem_we_n}, 32'h7);
        chk("abort_oe", {31'd0, mem_oe}, 32'd0);
        chk("abort_ready", {31'd0, cpu_ready}, 32'd0);
        chk("abort_gpio_out", {16'd0, gpio_out}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        chk("abort_no_ready", ready_cnt - rc, 32'd0);
        @(negedge clk);

        mem_rdata = 8'h77;
        xfer(1'b1, 1'b0, 16'h2100, 8'h00, 8'h77, 1'b1, 3, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
